// File: rtl/seq_prime_checker_pkg.sv
// Shared types and constants for the sequential prime checker.
package prime_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCREEN,
    DIV,
    STEP,
    DONE
  } state_t;

  localparam int FIRST_DIV = 3;
  localparam int FIRST_SQ  = 9;

endpackage

// File: rtl/seq_prime_checker_if.sv
// Candidate-in / result-out handshake bundle for the prime checker.
interface seq_prime_checker_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_num;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_num;
  logic             out_is_prime;
  logic [WIDTH-1:0] out_factor;

  modport master (
    output in_valid, in_num, out_ready,
    input  in_ready, out_valid, out_num, out_is_prime, out_factor
  );

  modport slave (
    input  in_valid, in_num, out_ready,
    output in_ready, out_valid, out_num, out_is_prime, out_factor
  );

endinterface

// File: rtl/seq_prime_checker_serial_mod.sv
// Restoring remainder unit: one dividend bit per cycle, done pulses WIDTH cycles after start.
module serial_mod #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    count;
  logic             busy;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;

  // The partial remainder is always below the divisor, so one extra bit covers the shift.
  always_comb begin
    trial = {rem_q, shreg[WIDTH-1]};
    diff  = trial - {1'b0, dvsr};
    fits  = (trial >= {1'b0, dvsr});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      dvsr  <= '0;
      rem_q <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg <= dividend;
        dvsr  <= divisor;
        rem_q <= '0;
        count <= CW'(WIDTH);
        busy  <= 1'b1;
      end else if (busy) begin
        rem_q <= fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        shreg <= shreg << 1;
        count <= count - CW'(1);
        if (count == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign rem = rem_q;

endmodule

// File: rtl/seq_prime_checker.sv
// Sequential prime checker: serial trial division by odd divisors until d*d exceeds n.
module seq_prime_checker
  import prime_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_prime_checker_if.slave  bus
);

  localparam int SW = 2 * WIDTH;

  state_t           state;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] d;
  logic [SW-1:0]    sq;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_num;
  logic             out_is_prime;
  logic [WIDTH-1:0] out_factor;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_rem;
  logic             sq_gt_n;

  assign sq_gt_n   = (sq > {{WIDTH{1'b0}}, n});
  assign div_start = (state == STEP) && !sq_gt_n;

  serial_mod #(.WIDTH(WIDTH)) u_mod (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (n),
    .divisor  (d),
    .done     (div_done),
    .rem      (div_rem)
  );

  // DONE spends its first cycle raising out_valid, then waits for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      n            <= '0;
      d            <= '0;
      sq           <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_num      <= '0;
      out_is_prime <= 1'b0;
      out_factor   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready) begin
            n        <= bus.in_num;
            out_num  <= bus.in_num;
            in_ready <= 1'b0;
            state    <= SCREEN;
          end
        end
        SCREEN: begin
          if (n < WIDTH'(2)) begin
            out_is_prime <= 1'b0;
            out_factor   <= '0;
            state        <= DONE;
          end else if (n == WIDTH'(2) || n == WIDTH'(3)) begin
            out_is_prime <= 1'b1;
            out_factor   <= '0;
            state        <= DONE;
          end else if (!n[0]) begin
            out_is_prime <= 1'b0;
            out_factor   <= WIDTH'(2);
            state        <= DONE;
          end else begin
            d     <= WIDTH'(FIRST_DIV);
            sq    <= SW'(FIRST_SQ);
            state <= STEP;
          end
        end
        STEP: begin
          if (sq_gt_n) begin
            out_is_prime <= 1'b1;
            out_factor   <= '0;
            state        <= DONE;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          if (div_done) begin
            if (div_rem == '0) begin
              out_is_prime <= 1'b0;
              out_factor   <= d;
              state        <= DONE;
            end else begin
              // (d+2)^2 = d^2 + 4d + 4, so the square tracks d without a multiplier.
              d     <= d + WIDTH'(2);
              sq    <= sq + ({{WIDTH{1'b0}}, d} << 2) + SW'(4);
              state <= STEP;
            end
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_num      = out_num;
  assign bus.out_is_prime = out_is_prime;
  assign bus.out_factor   = out_factor;

endmodule

// File: tb/tb_seq_prime_checker.sv
// Scoreboard bench for seq_prime_checker: a 32-bit and an 8-bit instance share clock and reset.
module tb_seq_prime_checker;

  typedef struct packed {
    logic [31:0] num;
    logic        is_prime;
    logic [31:0] factor;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  int unsigned n_compared = 0;
  int unsigned n_mismatch = 0;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32;
  exp_t e8;

  seq_prime_checker_if #(.WIDTH(32)) bus32();
  seq_prime_checker_if #(.WIDTH(8))  bus8();

  seq_prime_checker #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  seq_prime_checker #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic [31:0] num,
                               input logic is_prime, input logic [31:0] factor);
    int  waited = 0;
    bit  ready  = 1'b0;
    exp_t e;
    if (sel) begin
      bus8.in_num   = num[7:0];
      bus8.in_valid = 1'b1;
    end else begin
      bus32.in_num   = num;
      bus32.in_valid = 1'b1;
    end
    forever begin
      @(negedge clk);
      ready = sel ? bus8.in_ready : bus32.in_ready;
      if (ready) break;
      waited++;
      if (waited > 10000) begin
        n_compared++;
        n_mismatch++;
        $display("[TB] FAIL accept_timeout: in_ready never rose for num %0d", num);
        break;
      end
    end
    if (ready) begin
      e.num      = num;
      e.is_prime = is_prime;
      e.factor   = factor;
      if (sel) q8.push_back(e);
      else     q32.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sel) bus8.in_valid = 1'b0;
    else     bus32.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    int waited = 0;
    while ((sel ? (q8.size() != 0 || bus8.out_valid) : (q32.size() != 0 || bus32.out_valid))) begin
      @(posedge clk);
      #1;
      waited++;
      if (waited > 20000) begin
        n_compared++;
        n_mismatch++;
        $display("[TB] FAIL drain_timeout: results still pending on instance %0d", sel);
        break;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_in_ready32"},  32'(bus32.in_ready), 32'd1);
    checkOutput({tag, "_out_valid32"}, 32'(bus32.out_valid), 32'd0);
    checkOutput({tag, "_out_num32"},   bus32.out_num, 32'd0);
    checkOutput({tag, "_prime32"},     32'(bus32.out_is_prime), 32'd0);
    checkOutput({tag, "_factor32"},    bus32.out_factor, 32'd0);
    checkOutput({tag, "_in_ready8"},   32'(bus8.in_ready), 32'd1);
    checkOutput({tag, "_out_valid8"},  32'(bus8.out_valid), 32'd0);
    checkOutput({tag, "_out_num8"},    32'(bus8.out_num), 32'd0);
    checkOutput({tag, "_prime8"},      32'(bus8.out_is_prime), 32'd0);
    checkOutput({tag, "_factor8"},     32'(bus8.out_factor), 32'd0);
  endtask

  // Monitors pop one expectation per accepted result; any result without one is stale.
  always @(negedge clk) begin
    if (rst_n && bus32.out_valid && bus32.out_ready) begin
      if (q32.size() == 0) begin
        n_compared++;
        n_mismatch++;
        $display("[TB] FAIL unexpected_result32: got num %0d, required none", bus32.out_num);
      end else begin
        e32 = q32.pop_front();
        checkOutput("num32",    bus32.out_num, e32.num);
        checkOutput("prime32",  32'(bus32.out_is_prime), 32'(e32.is_prime));
        checkOutput("factor32", bus32.out_factor, e32.factor);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus8.out_valid && bus8.out_ready) begin
      if (q8.size() == 0) begin
        n_compared++;
        n_mismatch++;
        $display("[TB] FAIL unexpected_result8: got num %0d, required none", bus8.out_num);
      end else begin
        e8 = q8.pop_front();
        checkOutput("num8",    32'(bus8.out_num), e8.num);
        checkOutput("prime8",  32'(bus8.out_is_prime), 32'(e8.is_prime));
        checkOutput("factor8", 32'(bus8.out_factor), e8.factor);
      end
    end
  end

  logic [31:0] sweep_num    [12] = '{0, 1, 2, 3, 4, 5, 16, 17, 18, 19, 97, 100};
  logic        sweep_prime  [12] = '{0, 0, 1, 1, 0, 1, 0, 1, 0, 1, 1, 0};
  logic [31:0] sweep_factor [12] = '{0, 0, 0, 0, 2, 0, 2, 0, 2, 0, 0, 2};

  initial begin
    int lat;
    rst_n           = 1'b0;
    bus32.in_valid  = 1'b0;
    bus32.in_num    = '0;
    bus32.out_ready = 1'b1;
    bus8.in_valid   = 1'b0;
    bus8.in_num     = '0;
    bus8.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] sweep of small candidates");
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, sweep_num[i], sweep_prime[i], sweep_factor[i]);
    wait_idle(1'b0);

    $display("[TB] composites, latency and wide candidates");
    applyStimulus(1'b0, 32'd91, 1'b0, 32'd7);
    wait_idle(1'b0);
    applyStimulus(1'b0, 32'd97, 1'b1, 32'd0);
    lat = 0;
    while (!bus32.out_valid && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency97", 32'(lat), 32'd139);
    wait_idle(1'b0);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0, 32'd3);
    applyStimulus(1'b0, 32'd65521, 1'b1, 32'd0);
    applyStimulus(1'b0, 32'd196611, 1'b0, 32'd3);
    wait_idle(1'b0);

    $display("[TB] 8-bit instance");
    applyStimulus(1'b1, 32'd251, 1'b1, 32'd0);
    applyStimulus(1'b1, 32'd255, 1'b0, 32'd3);
    applyStimulus(1'b1, 32'd121, 1'b0, 32'd11);
    applyStimulus(1'b1, 32'd169, 1'b0, 32'd13);
    wait_idle(1'b1);

    $display("[TB] backpressure");
    bus32.out_ready = 1'b0;
    applyStimulus(1'b0, 32'd16, 1'b0, 32'd2);
    lat = 0;
    while (!bus32.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        bus32.in_num   = 32'd5;
        bus32.in_valid = 1'b1;
      end
      if (i == 6) bus32.in_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", 32'(bus32.out_valid), 32'd1);
      checkOutput("bp_in_ready",  32'(bus32.in_ready), 32'd0);
      checkOutput("bp_out_num",   bus32.out_num, 32'd16);
      checkOutput("bp_factor",    bus32.out_factor, 32'd2);
    end
    bus32.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_ready_after_accept", 32'(bus32.in_ready), 32'd1);
    applyStimulus(1'b0, 32'd19, 1'b1, 32'd0);
    checkOutput("bp_next_taken", 32'(bus32.in_ready), 32'd0);
    wait_idle(1'b0);

    $display("[TB] reset during a division");
    applyStimulus(1'b0, 32'd97, 1'b1, 32'd0);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    q32.delete();
    check_reset_values("midreset");
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'd17, 1'b1, 32'd0);
    wait_idle(1'b0);

    repeat (5) @(posedge clk);
    checkOutput("q32_empty", 32'(q32.size()), 32'd0);
    checkOutput("q8_empty",  32'(q8.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
